// File: rtl/cla_multiword_seq.sv
// Multi-word adder sequencer: adds W-bit operands one ADDER_SIZE chunk per clock
// through a single carry-lookahead adder, carry registered between chunks.

module cla_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_c,
   output logic             cout_c
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;
   logic             c_acc;
   logic             p_acc;

   // Every carry is a flat sum of generate terms and propagate products.
   always_comb begin
      gen      = a_i & b_i;
      prop     = a_i ^ b_i;
      carry    = '0;
      carry[0] = cin_i;
      c_acc    = 1'b0;
      p_acc    = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         c_acc = gen[i];
         p_acc = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            c_acc = c_acc | (p_acc & gen[j]);
            p_acc = p_acc & prop[j];
         end
         carry[i+1] = c_acc | (p_acc & cin_i);
      end
   end

   assign sum_c  = prop ^ carry[WIDTH-1:0];
   assign cout_c = carry[WIDTH];

endmodule

module cla_multiword_seq #(
   parameter int unsigned ADDER_SIZE = 8,
   parameter int unsigned NUM_CHUNKS = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ADDER_SIZE*NUM_CHUNKS-1:0] op_a,
   input  logic [ADDER_SIZE*NUM_CHUNKS-1:0] op_b,
   input  logic                             cin,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ADDER_SIZE*NUM_CHUNKS-1:0] sum,
   output logic                             cout,
   output logic                             busy
);

   localparam int unsigned W     = ADDER_SIZE * NUM_CHUNKS;
   localparam int unsigned IDX_W = $clog2(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [NUM_CHUNKS-1:0][ADDER_SIZE-1:0] word_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   word_t            opa_q, opa_d;
   word_t            opb_q, opb_d;
   word_t            sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;

   logic [ADDER_SIZE-1:0] add_sum_c;
   logic                  add_cout_c;

   cla_adder #(
      .WIDTH (ADDER_SIZE)
   ) u_cla_adder (
      .a_i    (opa_q[idx_q]),
      .b_i    (opb_q[idx_q]),
      .cin_i  (carry_q),
      .sum_c  (add_sum_c),
      .cout_c (add_cout_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next state; status flags are registered from the next state so they track it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               opa_d   = op_a;
               opb_d   = op_b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q] = add_sum_c;
            carry_d      = add_cout_c;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout_c;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = W'(sum_q);
   assign cout      = cout_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomized self-checking bench for cla_multiword_seq against a plain-arithmetic model.

module tb_cla_multiword_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   cla_multiword_seq #(
      .ADDER_SIZE (8),
      .NUM_CHUNKS (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {32'd0, c};
   endfunction

   // Accept one op at the next edge, return clocks until out_valid and the result.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic rdy, output int lat);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = rdy;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c);
      int lat;
      issue(a, b, c, 1'b1, lat);
      check({tag, "_lat"}, 64'(lat), 64'd4);
      check({tag, "_res"}, 64'({cout, sum}), 64'(model(a, b, c)));
      @(posedge clk);
      #1 check({tag, "_drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int          lat;
      int          last_acc;
      int          acc;
      int          waitc;
      logic [31:0] ra, rb;
      logic        rc;
      logic [32:0] held;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'({cout, sum}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      directed("t1", 32'h0000_00AB, 32'h0000_00CD, 1'b1);
      check("t1_sum_const", 64'(sum), 64'h179);
      directed("t2", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      check("t2_sum_const", 64'(sum), 64'hACF1_3568);
      directed("t3", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      check("t3_cout_const", 64'(cout), 64'd1);

      // Consumer stalls; a second request must not be taken.
      issue(32'h0000_009D, 32'h0000_00B2, 1'b0, 1'b0, lat);
      check("t4_lat", 64'(lat), 64'd4);
      held = model(32'h9D, 32'hB2, 1'b0);
      op_a = 32'h1111_1111; op_b = 32'h2222_2222; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_res", 64'({cout, sum}), 64'(held));
         check("t4_valid", 64'(out_valid), 64'd1);
         check("t4_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 check("t4_drop", 64'(out_valid), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);

      // Reset mid-operation.
      @(negedge clk);
      op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("t5_valid", 64'(out_valid), 64'd0);
      check("t5_sum", 64'(sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_in_ready", 64'(in_ready), 64'd1);
      waitc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) waitc++;
      end
      check("t5_no_valid", 64'(waitc), 64'd0);
      directed("t5b", 32'd1, 32'd1, 1'b0);

      // Back-to-back random ops with out_ready held high.
      out_ready = 1'b1;
      last_acc  = -1;
      for (int n = 0; n < 20; n++) begin
         waitc = 0;
         @(negedge clk);
         while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
         end
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1, 0));
         if (n == 3) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rc = 1'b1; end
         op_a = ra; op_b = rb; cin = rc; in_valid = 1'b1;
         @(posedge clk);
         acc = cycle;
         if (last_acc >= 0) check("t6_spacing", 64'(acc - last_acc), 64'd6);
         last_acc = acc;
         #1 op_a = $urandom; op_b = $urandom; cin = ~rc;
         waitc = 0;
         @(negedge clk);
         while (!out_valid && waitc < 20) begin
            @(negedge clk);
            waitc++;
         end
         check("t6_res", 64'({cout, sum}), 64'(model(ra, rb, rc)));
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
